// File: rtl/ub_controller.sv
// Unified buffer sequencer: arbitrates accumulator write-back against
// input-activation loads and drives the buffer's address and strobes.
module ub_controller #(
    parameter int ADDR_W     = 13,
    parameter int MEM_DEPTH  = 64,
    parameter int BURST      = 4,
    parameter int STORE_BASE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              acc1_full,
    input  logic              acc2_full,
    output logic              acc_drain,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              ld_err,
    input  logic              wr_ptr_clr,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              buf_full,
    output logic [ADDR_W-1:0] ub_addr,
    output logic              ub_store,
    output logic              ub_store_acc1,
    output logic              ub_store_acc2,
    output logic              ub_load_input
);

    typedef enum logic [1:0] {
        IDLE,
        STORE,
        LOAD,
        LOAD_WAIT
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [ADDR_W:0]   BURST_X = (ADDR_W+1)'(BURST);
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(STORE_BASE);
    localparam logic              BF_RST  =
        ({1'b0, BASE} + BURST_X) > DEPTH_X;

    state_t            state_q;
    logic              lg_store_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] wr_ptr_d;
    logic              buf_full_q;
    logic              buf_full_d;
    logic [ADDR_W-1:0] ub_addr_q;
    logic              ub_store_q;
    logic              ub_load_q;
    logic              acc_drain_q;
    logic              ld_done_q;
    logic              ld_err_q;

    logic st_elig;
    logic ld_rdy;
    logic grant_ld;
    logic grant_st;
    logic ld_oob;

    always_comb begin
        st_elig  = acc1_full & acc2_full & ~buf_full_q;
        // Round-robin: a pending load yields to a store only if it went last.
        ld_rdy   = (state_q == IDLE) &
                   ~(st_elig & ~(ld_req & lg_store_q));
        grant_ld = ld_req & ld_rdy;
        grant_st = (state_q == IDLE) & st_elig & ~grant_ld;
        ld_oob   = ({1'b0, ld_addr} + BURST_X) > DEPTH_X;

        wr_ptr_d = wr_ptr_q;
        if (wr_ptr_clr) begin
            wr_ptr_d = BASE;
        end else if (state_q == STORE) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(BURST);
        end
        buf_full_d = ({1'b0, wr_ptr_d} + BURST_X) > DEPTH_X;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            lg_store_q  <= 1'b0;
            wr_ptr_q    <= BASE;
            buf_full_q  <= BF_RST;
            ub_addr_q   <= '0;
            ub_store_q  <= 1'b0;
            ub_load_q   <= 1'b0;
            acc_drain_q <= 1'b0;
            ld_done_q   <= 1'b0;
            ld_err_q    <= 1'b0;
        end else begin
            ub_store_q  <= 1'b0;
            ub_load_q   <= 1'b0;
            acc_drain_q <= 1'b0;
            ld_done_q   <= 1'b0;
            ld_err_q    <= 1'b0;
            wr_ptr_q    <= wr_ptr_d;
            buf_full_q  <= buf_full_d;
            unique case (state_q)
                IDLE: begin
                    if (grant_st) begin
                        state_q    <= STORE;
                        ub_addr_q  <= wr_ptr_q;
                        ub_store_q <= 1'b1;
                        lg_store_q <= 1'b1;
                    end else if (grant_ld) begin
                        lg_store_q <= 1'b0;
                        if (ld_oob) begin
                            ld_err_q <= 1'b1;
                        end else begin
                            state_q   <= LOAD;
                            ub_addr_q <= ld_addr;
                            ub_load_q <= 1'b1;
                        end
                    end
                end
                STORE: begin
                    acc_drain_q <= 1'b1;
                    state_q     <= IDLE;
                end
                LOAD: begin
                    ld_done_q <= 1'b1;
                    state_q   <= LOAD_WAIT;
                end
                LOAD_WAIT: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ld_ready      = ld_rdy;
    assign acc_drain     = acc_drain_q;
    assign ld_done       = ld_done_q;
    assign ld_err        = ld_err_q;
    assign wr_ptr        = wr_ptr_q;
    assign buf_full      = buf_full_q;
    assign ub_addr       = ub_addr_q;
    assign ub_store      = ub_store_q;
    assign ub_store_acc1 = ub_store_q;
    assign ub_store_acc2 = ub_store_q;
    assign ub_load_input = ub_load_q;

endmodule

// File: tb/tb_ub_controller.sv
// Directed-vector bench for ub_controller: table-driven core sequence
// plus hand-written fill/clear and mid-load reset sequences.
module tb_ub_controller;

    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          reset;
    logic          acc1_full;
    logic          acc2_full;
    logic          acc_drain;
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic          ld_ready;
    logic          ld_done;
    logic          ld_err;
    logic          wr_ptr_clr;
    logic [AW-1:0] wr_ptr;
    logic          buf_full;
    logic [AW-1:0] ub_addr;
    logic          ub_store;
    logic          ub_store_acc1;
    logic          ub_store_acc2;
    logic          ub_load_input;

    int checks = 0;
    int errors = 0;

    ub_controller dut (
        .clk          (clk),
        .reset        (reset),
        .acc1_full    (acc1_full),
        .acc2_full    (acc2_full),
        .acc_drain    (acc_drain),
        .ld_req       (ld_req),
        .ld_addr      (ld_addr),
        .ld_ready     (ld_ready),
        .ld_done      (ld_done),
        .ld_err       (ld_err),
        .wr_ptr_clr   (wr_ptr_clr),
        .wr_ptr       (wr_ptr),
        .buf_full     (buf_full),
        .ub_addr      (ub_addr),
        .ub_store     (ub_store),
        .ub_store_acc1(ub_store_acc1),
        .ub_store_acc2(ub_store_acc2),
        .ub_load_input(ub_load_input)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          a1;
        logic          a2;
        logic          lr;
        logic [AW-1:0] la;
        int            rdy;
        logic          st;
        logic          ld;
        logic          drn;
        logic          done;
        logic          err;
        logic [AW-1:0] addr;
        logic [AW-1:0] wp;
        logic          bf;
    } vec_t;

    vec_t tbl[28];

    function automatic vec_t mk(
        input logic rst, input logic a1, input logic a2, input logic lr,
        input int la, input int rdy,
        input logic st, input logic ld, input logic drn,
        input logic done, input logic err,
        input int addr, input int wp, input logic bf);
        vec_t v;
        v.rst = rst; v.a1 = a1; v.a2 = a2; v.lr = lr;
        v.la = AW'(la); v.rdy = rdy;
        v.st = st; v.ld = ld; v.drn = drn; v.done = done; v.err = err;
        v.addr = AW'(addr); v.wp = AW'(wp); v.bf = bf;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic st,
                           input logic ld, input logic drn,
                           input logic done, input logic err,
                           input logic [AW-1:0] addr,
                           input logic [AW-1:0] wp, input logic bf);
        chk({tag, " ub_store"}, 32'(ub_store), 32'(st));
        chk({tag, " store_acc1"}, 32'(ub_store_acc1), 32'(st));
        chk({tag, " store_acc2"}, 32'(ub_store_acc2), 32'(st));
        chk({tag, " ub_load_input"}, 32'(ub_load_input), 32'(ld));
        chk({tag, " acc_drain"}, 32'(acc_drain), 32'(drn));
        chk({tag, " ld_done"}, 32'(ld_done), 32'(done));
        chk({tag, " ld_err"}, 32'(ld_err), 32'(err));
        chk({tag, " ub_addr"}, 32'(ub_addr), 32'(addr));
        chk({tag, " wr_ptr"}, 32'(wr_ptr), 32'(wp));
        chk({tag, " buf_full"}, 32'(buf_full), 32'(bf));
    endtask

    // Store and load strobes must never overlap.
    always @(negedge clk) begin
        checks++;
        if ((ub_store & ub_load_input) !== 1'b0) begin
            errors++;
            $display("FAIL strobe_overlap: got store=%b load=%b expected not both",
                     ub_store, ub_load_input);
        end
    end

    initial begin
        reset = 1'b0; acc1_full = 1'b0; acc2_full = 1'b0;
        ld_req = 1'b0; ld_addr = '0; wr_ptr_clr = 1'b0;

        //            rst a1 a2 lr la   rdy st ld dr dn er addr wp bf
        tbl[0]  = mk(0, 1, 1, 1, 0,    -1, 0, 0, 0, 0, 0, 0,    0,  0);
        tbl[1]  = mk(0, 1, 1, 1, 0,     0, 0, 0, 0, 0, 0, 0,    0,  0);
        tbl[2]  = mk(1, 1, 1, 0, 0,     0, 1, 0, 0, 0, 0, 0,    0,  0);
        tbl[3]  = mk(1, 1, 1, 0, 0,     0, 0, 0, 1, 0, 0, 0,    4,  0);
        tbl[4]  = mk(1, 1, 1, 0, 0,     0, 1, 0, 0, 0, 0, 4,    4,  0);
        tbl[5]  = mk(1, 1, 1, 0, 0,     0, 0, 0, 1, 0, 0, 4,    8,  0);
        tbl[6]  = mk(1, 1, 1, 0, 0,     0, 1, 0, 0, 0, 0, 8,    8,  0);
        tbl[7]  = mk(1, 0, 0, 0, 0,     0, 0, 0, 1, 0, 0, 8,    12, 0);
        tbl[8]  = mk(1, 0, 0, 0, 0,     1, 0, 0, 0, 0, 0, 8,    12, 0);
        tbl[9]  = mk(1, 0, 0, 1, 'h1E,  1, 0, 1, 0, 0, 0, 'h1E, 12, 0);
        tbl[10] = mk(1, 0, 0, 0, 0,     0, 0, 0, 0, 1, 0, 'h1E, 12, 0);
        tbl[11] = mk(1, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 'h1E, 12, 0);
        tbl[12] = mk(1, 1, 1, 1, 'h10,  0, 1, 0, 0, 0, 0, 12,   12, 0);
        tbl[13] = mk(1, 0, 0, 1, 'h10,  0, 0, 0, 1, 0, 0, 12,   16, 0);
        tbl[14] = mk(1, 0, 0, 1, 'h10,  1, 0, 1, 0, 0, 0, 'h10, 16, 0);
        tbl[15] = mk(1, 0, 0, 0, 0,     0, 0, 0, 0, 1, 0, 'h10, 16, 0);
        tbl[16] = mk(1, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 'h10, 16, 0);
        tbl[17] = mk(1, 1, 1, 0, 0,     0, 1, 0, 0, 0, 0, 16,   16, 0);
        tbl[18] = mk(1, 1, 1, 1, 'h20,  0, 0, 0, 1, 0, 0, 16,   20, 0);
        tbl[19] = mk(1, 1, 1, 1, 'h20,  1, 0, 1, 0, 0, 0, 'h20, 20, 0);
        tbl[20] = mk(1, 1, 1, 0, 0,     0, 0, 0, 0, 1, 0, 'h20, 20, 0);
        tbl[21] = mk(1, 1, 1, 0, 0,     0, 0, 0, 0, 0, 0, 'h20, 20, 0);
        tbl[22] = mk(1, 1, 1, 0, 0,     0, 1, 0, 0, 0, 0, 20,   20, 0);
        tbl[23] = mk(1, 0, 0, 0, 0,     0, 0, 0, 1, 0, 0, 20,   24, 0);
        tbl[24] = mk(1, 0, 0, 1, 61,    1, 0, 0, 0, 0, 1, 20,   24, 0);
        tbl[25] = mk(1, 0, 0, 1, 60,    1, 0, 1, 0, 0, 0, 60,   24, 0);
        tbl[26] = mk(1, 0, 0, 0, 0,     0, 0, 0, 0, 1, 0, 60,   24, 0);
        tbl[27] = mk(1, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 60,   24, 0);

        for (int i = 0; i < 28; i++) begin
            reset     = tbl[i].rst;
            acc1_full = tbl[i].a1;
            acc2_full = tbl[i].a2;
            ld_req    = tbl[i].lr;
            ld_addr   = tbl[i].la;
            #1;
            if (tbl[i].rdy >= 0)
                chk($sformatf("v%0d ld_ready", i), 32'(ld_ready),
                    32'(tbl[i].rdy));
            step();
            chk_out($sformatf("v%0d", i), tbl[i].st, tbl[i].ld,
                    tbl[i].drn, tbl[i].done, tbl[i].err,
                    tbl[i].addr, tbl[i].wp, tbl[i].bf);
        end

        // Fill from 24 up to the last legal slot at 60.
        acc1_full = 1'b1; acc2_full = 1'b1; ld_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_out($sformatf("fill%0d_st", i), 1, 0, 0, 0, 0,
                    AW'(24 + 4*i), AW'(24 + 4*i), 0);
            step();
            chk_out($sformatf("fill%0d_dr", i), 0, 0, 1, 0, 0,
                    AW'(24 + 4*i), AW'(28 + 4*i), (i == 9));
        end
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("full_stall%0d", i), 0, 0, 0, 0, 0,
                    AW'(60), AW'(64), 1);
        end

        // Loads still served while full.
        ld_req = 1'b1; ld_addr = AW'(8);
        #1;
        chk("full ld_ready", 32'(ld_ready), 32'(1));
        step();
        ld_req = 1'b0;
        chk_out("full_ld", 0, 1, 0, 0, 0, AW'(8), AW'(64), 1);
        step();
        chk_out("full_ld_done", 0, 0, 0, 1, 0, AW'(8), AW'(64), 1);
        step();

        wr_ptr_clr = 1'b1;
        step();
        wr_ptr_clr = 1'b0;
        chk_out("clr", 0, 0, 0, 0, 0, AW'(8), AW'(0), 0);
        step();
        chk_out("clr_store", 1, 0, 0, 0, 0, AW'(0), AW'(0), 0);
        acc1_full = 1'b0; acc2_full = 1'b0;
        step();
        chk_out("clr_drain", 0, 0, 1, 0, 0, AW'(0), AW'(4), 0);

        // Clear during STORE beats the increment.
        acc1_full = 1'b1; acc2_full = 1'b1;
        step();
        chk_out("st2", 1, 0, 0, 0, 0, AW'(4), AW'(4), 0);
        acc1_full = 1'b0; acc2_full = 1'b0; wr_ptr_clr = 1'b1;
        step();
        wr_ptr_clr = 1'b0;
        chk_out("st2_clr", 0, 0, 1, 0, 0, AW'(4), AW'(0), 0);

        // Reset while in LOAD abandons the load.
        ld_req = 1'b1; ld_addr = AW'('h1E);
        step();
        chk_out("rl_ld", 0, 1, 0, 0, 0, AW'('h1E), AW'(0), 0);
        ld_req = 1'b0; reset = 1'b0;
        step();
        chk_out("rl_rst", 0, 0, 0, 0, 0, AW'(0), AW'(0), 0);
        reset = 1'b1;
        step();
        chk_out("rl_after", 0, 0, 0, 0, 0, AW'(0), AW'(0), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ub_controller.md
Name: ub_controller

Overview:
- Sequences the unified buffer by driving its addr, store, load_input, store_acc1 and store_acc2 inputs.
- Arbitrates between accumulator write-back requests and input-activation load requests.
- Write-back lands at an auto-incrementing write pointer; loads read BURST words from a requester-supplied base address into the input-setup path.
- Sits between the top-level control and the unified buffer / accumulators.

Parameters:
ADDR_W, 13, width of unified buffer address
MEM_DEPTH, 64, number of 8-bit words in the unified buffer
BURST, 4, words moved per store or load (acc1_mem_0/1, acc2_mem_0/1)
STORE_BASE, 0, write-pointer value after reset or clear

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-low reset (reset==0 sampled at posedge clk resets the block)
acc1_full  in  1  accumulator 1 holds a complete result
acc2_full  in  1  accumulator 2 holds a complete result
acc_drain  out  1  one-cycle pulse: both accumulator results written, accumulators may clear
ld_req  in  1  load request, held until accepted
ld_addr  in  ADDR_W  base address of load; sampled on acceptance
ld_ready  out  1  controller can accept a load this cycle
ld_done  out  1  one-cycle pulse: unified buffer outputs hold the requested data
ld_err  out  1  one-cycle pulse: accepted load rejected as out of range
wr_ptr_clr  in  1  return write pointer to STORE_BASE
wr_ptr  out  ADDR_W  next write-back address
buf_full  out  1  no room for another BURST write-back
ub_addr  out  ADDR_W  to unified buffer addr
ub_store  out  1  to unified buffer store
ub_store_acc1  out  1  to unified buffer store_acc1
ub_store_acc2  out  1  to unified buffer store_acc2
ub_load_input  out  1  to unified buffer load_input

Behaviour:
- All outputs registered. Reset values:
  - all 1-bit outputs 0
  - ub_addr = 0
  - wr_ptr = STORE_BASE
  - state = IDLE
  - last_grant = LOAD
- Reset takes effect from any state, including mid-store or mid-load: the in-flight operation is abandoned, no acc_drain and no ld_done are issued.
- buf_full = (wr_ptr + BURST > MEM_DEPTH), computed with ADDR_W+1 bits; registered alongside wr_ptr.
- st_elig = acc1_full & acc2_full & !buf_full.
- ld_ready = (state==IDLE) & !(st_elig & !(ld_req & last_grant==STORE)). A load is accepted when ld_req & ld_ready at a posedge.
- FSM states: IDLE, STORE, LOAD, LOAD_WAIT.
- IDLE arbitration:
  - if st_elig and ld_req both true: the grant goes opposite to last_grant (round-robin).
  - otherwise whichever is requesting is granted.
  - nothing requesting: stay in IDLE.
- Grant store -> STORE next cycle:
  - ub_addr = wr_ptr.
  - ub_store = ub_store_acc1 = ub_store_acc2 = 1 for exactly 1 cycle.
  - last_grant <= STORE.
- Leaving STORE:
  - strobes drop to 0.
  - wr_ptr <= wr_ptr + BURST.
  - acc_drain pulses for 1 cycle, in the cycle after STORE.
  - return to IDLE.
  - ub_addr is held stable for the whole STORE cycle, because the buffer write path is combinational on store.
- Grant load -> latch ld_addr and set last_grant <= LOAD.
  - If ld_addr + BURST > MEM_DEPTH: ld_err pulses 1 cycle, no buffer access, state stays IDLE.
  - Otherwise -> LOAD: ub_addr = latched ld_addr, ub_load_input = 1 for 1 cycle. The buffer registers its outputs at the end of this cycle.
  - -> LOAD_WAIT: ld_done = 1 for 1 cycle, then IDLE.
- Latency from an accepted ld_req edge: ub_load_input high in the next cycle; ld_done 2 cycles after acceptance.
- Minimum spacing: store 2 cycles, load 3 cycles, IDLE to IDLE.
- ub_store and ub_load_input are never high in the same cycle.
- buf_full: store is not granted, acc_drain is not issued, and the accumulators stall holding full. Loads continue to be served.
- No wrap-around: wr_ptr never exceeds MEM_DEPTH-BURST+... past the full check; only wr_ptr_clr or reset rewinds it.
- wr_ptr_clr:
  - Applies at the next edge: wr_ptr <= STORE_BASE.
  - If asserted during STORE, the clear wins over the increment.
  - Does not abort an in-flight operation.
- acc1_full or acc2_full dropping while in STORE does not cancel the store that is already issued.

Test Plan:
- Reset: hold reset=0 for 2 cycles with ld_req=1 and acc*_full=1 -> every output 0, wr_ptr=0; first grant occurs 1 cycle after reset=1.
- Store sequence: acc1_full=acc2_full=1 for three back-to-back results ->
  - ub_store pulses with ub_addr=0, 4, 8.
  - acc_drain pulses one cycle after each store.
  - wr_ptr ends at 12.
- Load: ld_req with ld_addr=0x1E ->
  - ub_load_input=1 with ub_addr=0x1E one cycle after acceptance.
  - ld_done two cycles after acceptance; the buffer outputs read 11, 12, 21, 22.
- Simultaneous requests: ld_req and st_elig together with last_grant=LOAD -> store first, then load. Repeat with last_grant=STORE -> load first, so neither requester is starved.
- Boundaries:
  - ld_addr=61 -> ld_err pulse, no ub_load_input.
  - Fill to wr_ptr=60 with one more store, reaching 64 -> buf_full=1; a further acc*_full pair gets no store and no acc_drain.
  - Pulse wr_ptr_clr -> wr_ptr=0, buf_full=0, and the pending store then issues at addr 0.
- Mid-operation reset: assert reset=0 during LOAD -> no ld_done, state IDLE, ub_load_input=0 on the next cycle.
